// File: rtl/lfsr_period_monitor.sv
// lfsr_period_monitor: measures the period of an LFSR from a captured seed, tracks the HD range,
// flags lock-up/timeout and hands one result record downstream on a valid/ready handshake.
module lfsr_period_monitor #(
    parameter int WIDTH     = 8,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 65535
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             init_valid_i,
    input  logic [WIDTH-1:0] init_seed_i,
    input  logic             step_valid_i,
    input  logic [WIDTH-1:0] lfsr_q_i,
    input  logic [WIDTH-1:0] hd_i,
    input  logic             result_ready_i,
    output logic             result_valid_o,
    output logic [CNT_W-1:0] period_o,
    output logic [WIDTH-1:0] hd_min_o,
    output logic [WIDTH-1:0] hd_max_o,
    output logic             lockup_o,
    output logic             timeout_o,
    output logic             busy_o
);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STEPS);

    typedef enum logic [1:0] {IDLE, TRACK, REPORT} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d, run_min_q, run_min_d, run_max_q, run_max_d;
    logic [WIDTH-1:0] hd_min_q, hd_min_d, hd_max_q, hd_max_d, min_n, max_n;
    logic [CNT_W-1:0] count_q, count_d, period_q, period_d, count_n;
    logic             lockup_q, lockup_d, timeout_q, timeout_d;
    logic             hs, start, step, hit_zero, hit_seed, hit_max, term;

    // init wins over a coincident step; in REPORT it is only taken together with a handshake
    always_comb begin
        hs       = state_q == REPORT && result_ready_i;
        start    = init_valid_i && (state_q != REPORT || hs);
        step     = state_q == TRACK && step_valid_i && !init_valid_i;
        count_n  = count_q + 1'b1;
        min_n    = hd_i < run_min_q ? hd_i : run_min_q;
        max_n    = hd_i > run_max_q ? hd_i : run_max_q;
        hit_zero = lfsr_q_i == '0;
        hit_seed = lfsr_q_i == seed_q;
        hit_max  = count_n == MAX_C;
        term     = hit_zero || hit_seed || hit_max;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = start ? (init_seed_i == '0 ? REPORT : TRACK) :
                  step  ? (term ? REPORT : TRACK) :
                  hs    ? IDLE : state_q;
    end

    always_comb begin
        result_valid_o = state_q == REPORT;
        busy_o         = state_q == TRACK;
        period_o       = period_q;
        hd_min_o       = hd_min_q;
        hd_max_o       = hd_max_q;
        lockup_o       = lockup_q;
        timeout_o      = timeout_q;
    end

    always_comb begin
        seed_d    = seed_q;
        count_d   = count_q;
        run_min_d = run_min_q;
        run_max_d = run_max_q;
        period_d  = period_q;
        hd_min_d  = hd_min_q;
        hd_max_d  = hd_max_q;
        lockup_d  = lockup_q;
        timeout_d = timeout_q;
        if (start) begin
            seed_d    = init_seed_i;
            count_d   = '0;
            run_min_d = '1;
            run_max_d = '0;
            lockup_d  = init_seed_i == '0;
            timeout_d = 1'b0;
            if (init_seed_i == '0) begin
                period_d = '0;
                hd_min_d = '0;
                hd_max_d = '0;
            end
        end else if (step) begin
            count_d   = count_n;
            run_min_d = min_n;
            run_max_d = max_n;
            if (term) begin
                period_d  = count_n;
                hd_min_d  = min_n;
                hd_max_d  = max_n;
                lockup_d  = hit_zero;
                timeout_d = !hit_zero && !hit_seed;
            end
        end else if (hs) begin
            lockup_d  = 1'b0;
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seed_q    <= '0;
            count_q   <= '0;
            run_min_q <= '0;
            run_max_q <= '0;
            period_q  <= '0;
            hd_min_q  <= '0;
            hd_max_q  <= '0;
            lockup_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            seed_q    <= seed_d;
            count_q   <= count_d;
            run_min_q <= run_min_d;
            run_max_q <= run_max_d;
            period_q  <= period_d;
            hd_min_q  <= hd_min_d;
            hd_max_q  <= hd_max_d;
            lockup_q  <= lockup_d;
            timeout_q <= timeout_d;
        end
    end
endmodule

// File: doc/lfsr_period_monitor.md
Name: lfsr_period_monitor

Overview:
Downstream consumer of the LFSR processor's per-step state (LFSR_q) and Hamming-distance (HD) outputs. Captures the seed on an init event. Counts run steps until the register returns to that seed, which gives the sequence period. Tracks min/max HD over the sequence, flags lock-up (all-zero state) and timeout, and presents one result record on a valid/ready handshake to a downstream logger or memory writer.

Parameters:
WIDTH, 8, LFSR state and HD width
CNT_W, 16, period counter width
MAX_STEPS, 65535, step limit before timeout (must be < 2^CNT_W)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
init_valid  in  1  one-cycle pulse: new seed loaded into LFSR
init_seed  in  WIDTH  seed value, sampled when init_valid=1
step_valid  in  1  one-cycle pulse per run step
lfsr_q  in  WIDTH  LFSR state after this step, sampled when step_valid=1
hd  in  WIDTH  HD between previous and current state, sampled with step_valid
result_ready  in  1  downstream accepts result
result_valid  out  1  result record valid
period  out  CNT_W  steps taken to return to seed
hd_min  out  WIDTH  minimum HD over counted steps
hd_max  out  WIDTH  maximum HD over counted steps
lockup  out  1  seed or a stepped state was all-zero
timeout  out  1  MAX_STEPS reached without returning to seed
busy  out  1  state is TRACK

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including result_valid, period, hd_min, hd_max, lockup, timeout and busy.
  - Internal seed, count and min/max registers are 0.
- FSM states: IDLE, TRACK, REPORT.
- IDLE:
  - step_valid is ignored.
  - On init_valid: seed <= init_seed, count <= 0, run_min <= all-ones, run_max <= 0.
  - If init_seed == 0, load lockup=1, period=0, hd_min=0, hd_max=0 and go to REPORT.
  - Otherwise go to TRACK.
- TRACK (busy=1):
  - On step_valid: count_n = count+1; run_min = min(run_min, hd); run_max = max(run_max, hd).
  - Terminating conditions are checked in priority order on that same step:
    - lfsr_q == 0: lockup=1, go to REPORT.
    - lfsr_q == seed: go to REPORT.
    - count_n == MAX_STEPS: timeout=1, go to REPORT.
    - Otherwise stay in TRACK with count <= count_n.
  - On REPORT entry, output registers load period=count_n, hd_min=run_min', hd_max=run_max' (values including the current step).
  - init_valid in TRACK restarts the measurement exactly as in IDLE. init_valid has priority over step_valid in the same cycle; that step is discarded.
- REPORT:
  - result_valid=1 from the cycle after the terminating event, i.e. one cycle latency.
  - period, hd_min, hd_max, lockup and timeout hold stable while result_valid=1 and result_ready=0.
  - Handshake occurs when result_valid & result_ready. Next cycle: result_valid=0, lockup=0, timeout=0, state IDLE. period and hd_min/hd_max keep their last values.
  - step_valid is ignored in REPORT.
  - init_valid without a handshake in the same cycle is ignored.
  - init_valid coincident with a handshake is accepted: the handshake completes, result_valid=0, and the FSM enters TRACK (or REPORT again if the seed is 0).
- Arithmetic:
  - count is unsigned CNT_W and never wraps, because timeout stops it at MAX_STEPS.
  - min/max are unsigned comparisons on WIDTH bits.
- Flag exclusivity: lockup and timeout are never both 1. Seed match is reported with both flags 0.
- Reset mid-TRACK or mid-REPORT discards everything. No result is emitted.

Test Plan:
- Reset with reset=0 mid-sequence -> all outputs 0, busy=0. After reset=1, step_valid pulses produce no result_valid.
- init_seed=8'h01, then steps (lfsr_q,hd) = (8'h03,1), (8'h05,2), (8'h01,1), result_ready=1 -> result_valid one cycle after the 3rd step; period=3, hd_min=1, hd_max=2, lockup=0, timeout=0.
- init_seed=8'h00 -> result_valid next cycle with lockup=1, period=0, hd_min=0, hd_max=0. Separately, seed 8'h0F with step lfsr_q=8'h00, hd=4 -> lockup=1, period=1, hd_min=hd_max=4.
- MAX_STEPS=4, seed 8'hA5, four steps never matching seed or 0 -> timeout=1, period=4.
- Result with result_ready held 0 for 5 cycles -> result_valid and all fields stable. Then result_ready=1 with init_valid=1 (seed 8'h22) in the same cycle -> result_valid=0 next cycle, busy=1.
- Seed 8'h01 on 255-step maximal-length sequence from the bench model -> period=255. Also: init_valid and step_valid in the same TRACK cycle -> count restarts at 0 and the step is discarded.
